// File: rtl/dcache_store_buffer_pkg.sv
// Shared constants for the data-cache store buffer.
// Holds the default depth, the store-size encoding and where block numbers start in an address.
package dcache_store_buffer_pkg;
  localparam int   SB_DEPTH = 4;
  localparam logic SZ_4B    = 1'b0;
  localparam logic SZ_8B    = 1'b1;
  localparam int   BLK_LSB  = 3;
endpackage

// File: rtl/dcache_store_buffer_conflict.sv
// Conservative overlap test between one load block and one buffered store block.
// Adjacent blocks count as overlapping, so accesses that cross a block boundary are covered.
module sb_block_conflict #(
  parameter int BW = 29
) (
  input  logic [BW-1:0] ld_blk,
  input  logic [BW-1:0] st_blk,
  output logic          conflict
);
  logic [BW-1:0] ld_nxt;
  logic [BW-1:0] st_nxt;

  // Incrementing at BW bits wraps the top block around to block 0.
  assign ld_nxt   = ld_blk + BW'(1);
  assign st_nxt   = st_blk + BW'(1);
  assign conflict = (ld_blk == st_blk) | (ld_nxt == st_blk) | (st_nxt == ld_blk);
endmodule

// File: rtl/dcache_store_buffer.sv
// In-order buffer of committed stores that drains to the data cache one store at a time.
// Loads pass straight through unless they might overlap a buffered store, or a drain is pending.
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     st_size,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     wr_req_valid,
  input  logic                     wr_req_ready,
  output logic [ADDR_W-1:0]        wr_req_address,
  output logic [DATA_W-1:0]        wr_req_data,
  output logic                     wr_size_out,
  output logic                     rd_req_valid,
  input  logic                     rd_req_ready,
  output logic [ADDR_W-1:0]        rd_req_address,
  input  logic                     drain_req,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = ADDR_W - BLK_LSB;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              size_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;

  logic              push;
  logic              pop;
  logic [DEPTH-1:0]  conflict;
  logic              hazard;
  logic              block_ld;

  assign st_ready       = (count_q != CW'(DEPTH));
  assign wr_req_valid   = (count_q != '0);
  assign push           = st_valid & st_ready;
  assign pop            = wr_req_valid & wr_req_ready;
  assign wr_req_address = addr_q[head_q];
  assign wr_req_data    = data_q[head_q];
  assign wr_size_out    = size_q[head_q];
  assign sb_empty       = (count_q == '0);
  assign sb_count       = count_q;

  // Entry payload needs no reset; valid bits and pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      size_q[tail_q] <= st_size;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        tail_q          <= tail_q + PW'(1);
        valid_q[tail_q] <= 1'b1;
      end
      if (pop) begin
        head_q          <= head_q + PW'(1);
        valid_q[head_q] <= 1'b0;
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_conf
    sb_block_conflict #(.BW(BW)) u_conf (
      .ld_blk   (ld_addr[ADDR_W-1:BLK_LSB]),
      .st_blk   (addr_q[i][ADDR_W-1:BLK_LSB]),
      .conflict (conflict[i])
    );
  end

  // A popping entry is still valid this cycle; a same-cycle push is younger than the load.
  assign hazard         = |(valid_q & conflict);
  assign block_ld       = hazard | (drain_req & ~sb_empty);
  assign rd_req_valid   = ld_valid & ~block_ld & ~reset;
  assign ld_ready       = rd_req_ready & ~block_ld & ~reset;
  assign rd_req_address = ld_addr;
endmodule

// File: tb/tb_dcache_store_buffer.sv
// Randomised and directed checks of the store buffer against a queue-based model.
module tb_dcache_store_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready, st_size;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic        wr_req_valid, wr_req_ready, wr_size_out;
  logic [31:0] wr_req_address;
  logic [63:0] wr_req_data;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_address;
  logic        drain_req, sb_empty;
  logic [2:0]  sb_count;

  dcache_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_address(wr_req_address),
    .wr_req_data(wr_req_data), .wr_size_out(wr_size_out),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_address(rd_req_address),
    .drain_req(drain_req), .sb_empty(sb_empty), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic        sz;
  } st_t;

  st_t sbq[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  logic        obs_ld_ready, obs_st_ready, obs_popped;
  logic [31:0] obs_wr_addr;
  logic [2:0]  obs_count_after;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic model_block(input logic [31:0] la, input logic dr);
    logic [28:0] lb, lb1, sb, sb1;
    logic h;
    h   = 1'b0;
    lb  = la[31:3];
    lb1 = lb + 29'd1;
    foreach (sbq[i]) begin
      sb  = sbq[i].addr[31:3];
      sb1 = sb + 29'd1;
      if (lb == sb || lb1 == sb || sb1 == lb) h = 1'b1;
    end
    return h || (dr && sbq.size() != 0);
  endfunction

  // One clock cycle: drive, check all outputs against the model, then advance the model.
  task automatic cyc(input logic sv, input logic [31:0] sa, input logic [63:0] sd, input logic ss,
                     input logic lv, input logic [31:0] la, input logic wrr, input logic rdr,
                     input logic dr);
    int   n;
    logic blk, do_push, do_pop;
    st_t  e;
    st_valid = sv; st_addr = sa; st_data = sd; st_size = ss;
    ld_valid = lv; ld_addr = la; wr_req_ready = wrr; rd_req_ready = rdr; drain_req = dr;
    #1;
    n = sbq.size();
    chk("count", 64'(sb_count), 64'(n));
    chk("empty", 64'(sb_empty), 64'(n == 0));
    chk("st_ready", 64'(st_ready), 64'(n < 4));
    chk("wr_valid", 64'(wr_req_valid), 64'(n != 0));
    if (n != 0) begin
      chk("wr_addr", 64'(wr_req_address), 64'(sbq[0].addr));
      chk("wr_data", wr_req_data, sbq[0].data);
      chk("wr_size", 64'(wr_size_out), 64'(sbq[0].sz));
    end
    blk = model_block(la, dr);
    chk("rd_valid", 64'(rd_req_valid), 64'(lv && !blk));
    chk("ld_ready", 64'(ld_ready), 64'(rdr && !blk));
    chk("rd_addr", 64'(rd_req_address), 64'(la));
    obs_ld_ready = ld_ready;
    obs_st_ready = st_ready;
    obs_wr_addr  = wr_req_address;
    do_push = sv && (n < 4);
    do_pop  = (n != 0) && wrr;
    obs_popped = do_pop;
    @(posedge clk);
    if (do_pop) void'(sbq.pop_front());
    if (do_push) begin
      e.addr = sa; e.data = sd; e.sz = ss;
      sbq.push_back(e);
    end
    @(negedge clk);
    #1 obs_count_after = sb_count;
  endtask

  task automatic push_st(input logic [31:0] a);
    cyc(1'b1, a, {$urandom, $urandom}, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic wrr);
    cyc(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, wrr, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] exp_a;
    reset = 1'b1;
    st_valid = 0; st_addr = 0; st_data = 0; st_size = 0;
    ld_valid = 1; ld_addr = 32'h40; wr_req_ready = 0; rd_req_ready = 1; drain_req = 0;
    #1;
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_count", 64'(sb_count), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_rd_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fill with cache stalled, then drain in order.
    for (int i = 0; i < 4; i++) push_st(32'h100 + 32'(i * 8));
    cyc(1'b1, 32'h500, 64'h1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("full_st_ready", 64'(obs_st_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      exp_a = 32'h100 + 32'(i * 8);
      chk("drain_order", 64'(obs_wr_addr), 64'(exp_a));
    end
    chk("drained_empty", 64'(sb_empty), 64'd1);

    // Full buffer refuses a push in its pop cycle; at count 2 push+pop keeps count.
    for (int i = 0; i < 4; i++) push_st(32'h300 + 32'(i * 8));
    cyc(1'b1, 32'h600, 64'h2, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("full_pop_count", 64'(obs_count_after), 64'd3);
    idle(1'b1);
    cyc(1'b1, 32'h700, 64'h3, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pushpop_count", 64'(obs_count_after), 64'd2);
    idle(1'b1);
    idle(1'b1);
    chk("pushpop_order", 64'(obs_wr_addr), 64'h700);

    // Hazards against a store at 0x200.
    push_st(32'h200);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h1FC, 1'b0, 1'b1, 1'b0);
    chk("haz_below", 64'(obs_ld_ready), 64'd0);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h20C, 1'b0, 1'b1, 1'b0);
    chk("haz_above", 64'(obs_ld_ready), 64'd0);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h218, 1'b0, 1'b1, 1'b0);
    chk("haz_clear", 64'(obs_ld_ready), 64'd1);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h20C, 1'b1, 1'b1, 1'b0);
    chk("haz_popping", 64'(obs_ld_ready), 64'd0);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h20C, 1'b0, 1'b1, 1'b0);
    chk("haz_after_pop", 64'(obs_ld_ready), 64'd1);

    // Block-number wrap-around.
    push_st(32'hFFFF_FFF8);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("haz_wrap", 64'(obs_ld_ready), 64'd0);
    idle(1'b1);

    // Same-cycle store push does not block the older load.
    cyc(1'b1, 32'h900, 64'h5, 1'b0, 1'b1, 32'h900, 1'b0, 1'b1, 1'b0);
    chk("push_no_block", 64'(obs_ld_ready), 64'd1);
    idle(1'b1);

    // Drain with two unrelated entries, then with an empty buffer.
    push_st(32'h400);
    push_st(32'h408);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h800, 1'b0, 1'b1, 1'b1);
    chk("drain_hold", 64'(obs_ld_ready), 64'd0);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h800, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h800, 1'b1, 1'b1, 1'b1);
    chk("drain_last_pop", 64'(obs_ld_ready), 64'd0);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h800, 1'b0, 1'b1, 1'b1);
    chk("drain_release", 64'(obs_ld_ready), 64'd1);
    cyc(1'b0, 0, 0, 0, 1'b1, 32'h800, 1'b0, 1'b0, 1'b1);
    chk("drain_follow", 64'(obs_ld_ready), 64'd0);

    // Randomised traffic concentrated on a few blocks to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom), 32'h1000 + 32'($urandom_range(0, 15) * 4), {$urandom, $urandom},
          1'($urandom), 1'($urandom), 32'hFF0 + 32'($urandom_range(0, 23) * 4),
          1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    // Mid-cycle reset with three entries held.
    while (sbq.size() != 0) idle(1'b1);
    for (int i = 0; i < 3; i++) push_st(32'hA00 + 32'(i * 8));
    ld_valid = 1'b1; ld_addr = 32'hF00; rd_req_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_empty", 64'(sb_empty), 64'd1);
    chk("mid_rst_count", 64'(sb_count), 64'd0);
    chk("mid_rst_wr_valid", 64'(wr_req_valid), 64'd0);
    chk("mid_rst_rd_valid", 64'(rd_req_valid), 64'd0);
    chk("mid_rst_ld_ready", 64'(ld_ready), 64'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_store_buffer.md
Name: dcache_store_buffer

Overview:
- Small in-order FIFO of committed stores between the memory stage and the data cache write interface.
- Accepts stores from the pipeline at up to one per cycle and drains them to the cache one at a time over a valid/ready handshake.
- Passes loads through to the cache read interface and holds any load that may overlap a buffered store, so a load never reads data older than a pending store.

Parameters:
DEPTH, 4, number of store entries; must be a power of two, at least 2.
ADDR_W, 32, address width.
DATA_W, 64, store data width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
st_valid  in  1  store request from the memory stage
st_ready  out  1  buffer can accept a store
st_addr  in  ADDR_W  store byte address
st_data  in  DATA_W  store data, little-endian, byte 0 in [7:0]
st_size  in  1  0 = 4-byte store, 1 = 8-byte store
ld_valid  in  1  load request from the memory stage
ld_ready  out  1  load accepted this cycle
ld_addr  in  ADDR_W  load byte address; the load reads 8 bytes
wr_req_valid  out  1  head store presented to the cache
wr_req_ready  in  1  cache accepts the head store
wr_req_address  out  ADDR_W  head entry address
wr_req_data  out  DATA_W  head entry data
wr_size_out  out  1  head entry size
rd_req_valid  out  1  load forwarded to the cache
rd_req_ready  in  1  cache accepts the load
rd_req_address  out  ADDR_W  equal to ld_addr
drain_req  in  1  block all new loads until the buffer is empty (serialising operations)
sb_empty  out  1  buffer holds no entries
sb_count  out  log2(DEPTH)+1  number of occupied entries

Behaviour:
- Only clk is used. reset asynchronously clears head, tail, count and all entry valid bits.
- Values during and after reset: sb_empty=1, sb_count=0, wr_req_valid=0, st_ready=1. rd_req_valid and ld_ready are 0 while reset is high.
- Storage: DEPTH entries {addr, data, size}, plus head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count.
- Push: push = st_valid & st_ready. The entry is written at tail on the clock edge and tail increments. st_ready = (count != DEPTH). A full buffer does not accept a push in the same cycle as a pop.
- Pop: wr_req_valid = (count != 0). wr_req_address, wr_req_data and wr_size_out come from the head entry through a combinational path with no gating. pop = wr_req_valid & wr_req_ready, after which head increments.
- Push and pop in the same cycle leave count unchanged. Push alone adds 1 to count; pop alone subtracts 1.
- Write-side latency: a store pushed at edge N is presented on wr_req_valid in cycle N+1 at the earliest.
- Once wr_req_valid rises, wr_req_valid and the head fields stay stable until pop.
- Hazard check uses block numbers blk = addr[ADDR_W-1:3], with arithmetic modulo 2^(ADDR_W-3).
- A load conflicts with a valid entry if ld_blk == st_blk, ld_blk+1 == st_blk, or st_blk+1 == ld_blk. This is deliberately conservative and covers unaligned loads and stores that straddle two blocks.
- hazard = OR over all valid entries of the conflict test. An entry popping in the current cycle still counts as valid.
- block_ld = hazard | (drain_req & ~sb_empty).
- Load pass-through is combinational: rd_req_valid = ld_valid & ~block_ld, ld_ready = rd_req_ready & ~block_ld, rd_req_address = ld_addr.
- A store being pushed in the same cycle as a load does not block that load. The load is older in program order.
- When drain_req is asserted with an empty buffer, loads are not blocked.
- Reset mid-operation discards all buffered stores with no writes issued. The cache side is responsible for abandoning any in-flight handshake.
- No internal FSM is needed beyond the pointer and count state. The ready/valid handshakes are the sequencing mechanism.

Decomposition:
- Shared package holds SB_DEPTH, SZ_4B=1'b0, SZ_8B=1'b1, and the blk slice constant BLK_LSB=3.
- One sub-module is natural: sb_block_conflict, a combinational test of one ld_blk against one st_blk, instantiated once per entry.

Test Plan:
- Reset: assert reset mid-cycle with 3 entries held -> sb_empty=1, sb_count=0 and wr_req_valid=0 immediately, with no clock edge required.
- Fill and drain, wr_req_ready=0: push 4 stores at 0x100, 0x108, 0x110, 0x118 -> st_ready=0 after the 4th. Then set wr_req_ready=1 -> exactly 4 pops in order 0x100..0x118, then sb_empty=1.
- Simultaneous push and pop: count=4 -> st_ready=0 and no push in the pop cycle. Count=2 with push and pop in the same cycle -> sb_count stays 2 and FIFO order is preserved.
- Load hazards with a store at 0x200 (blk 0x40) buffered:
  - load at 0x1FC (blk 0x3F) -> ld_ready=0.
  - load at 0x20C (blk 0x41) -> ld_ready=0.
  - load at 0x218 (blk 0x43) -> passes, with rd_req_address=0x218.
  - after the store pops -> the 0x20C load is accepted on the next rd_req_ready.
- Wrap-around: with a store at 0xFFFFFFF8, a load at 0x00000000 -> blocked, because block 0 equals 0x1FFFFFFF+1 mod 2^29.
- Drain: drain_req=1 with 2 non-conflicting entries -> loads held until the 2nd pop, then ld_ready follows rd_req_ready. drain_req=1 with the buffer empty -> no stall.
